pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and branch-flush controller for the five-stage PipelineMIPS core. It sits beside the IF/ID and ID/EX pipeline registers. It detects load-use hazards between the instruction in ID and a load in EX, and resolves taken branches in EX as `branch & zero`. It drives the PC, IF/ID and ID/EX write enables, bubble insertion and flush signals through a small state machine that supports multi-cycle stall and flush windows.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/load_use_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the PipelineMIPS hazard/flush controller.
// Imported by the controller, its interface and the pipeline registers.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hz_state_t;

   localparam int DEF_REG_W = 5;

   // sll $0,$0,0: what a bubbled or flushed pipeline register holds
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // The first window cycle is spent in RUN, so the counter is loaded with cyc-2
   function automatic logic [1:0] win_cnt(input int cyc);
      return 2'(cyc - 2);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX fields and freeze in, pipeline enables out.
// Optional perf counters appear only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(parameter int REG_W = pipe_ctrl_pkg::DEF_REG_W);
   logic             freeze;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rt;
   logic             ex_branch;
   logic             ex_zero;
   logic             pc_write;
   logic             pc_src;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_bubble;
`ifdef PIPE_HAZARD_PERF_EN
   logic [15:0]      stall_cnt;
   logic [15:0]      flush_cnt;

   modport slave (
      input  freeze, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch, ex_zero,
      output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
      output stall_cnt, flush_cnt
   );
   modport master (
      output freeze, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch, ex_zero,
      input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
      input  stall_cnt, flush_cnt
   );
`else
   modport slave (
      input  freeze, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch, ex_zero,
      output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble
   );
   modport master (
      output freeze, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch, ex_zero,
      input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble
   );
`endif
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID instruction and a load in EX.
// Kept standalone so the forwarding unit can reuse it.
module load_use_detect #(
   parameter int REG_W = pipe_ctrl_pkg::DEF_REG_W
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   output logic             hz
);
   // $0 is hardwired, so a load into it never creates a dependency
   assign hz = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for the five-stage pipeline.
// Define PIPE_HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W          = DEF_REG_W,
   parameter int LOAD_STALL_CYC = 1,
   parameter int BR_FLUSH_CYC   = 1
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  bus
);

   hz_state_t  state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       hz, tk;
   logic       stall_bub;
   logic       pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;

   load_use_detect #(.REG_W(REG_W)) u_lud (
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_uses_rt  (bus.id_uses_rt),
      .ex_mem_read (bus.ex_mem_read),
      .ex_rt       (bus.ex_rt),
      .hz          (hz)
   );

   assign tk = bus.ex_branch && bus.ex_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_bub    = 1'b0;
      if (rst) begin
         state_nxt = RUN;
         cnt_nxt   = 2'd0;
      end else if (!bus.freeze) begin
         id_ex_write = 1'b1;
         if (state == FLUSH) begin
            // Wrong-path instructions: their hazards and branches are meaningless
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (cnt == 2'd0) state_nxt = RUN;
            else             cnt_nxt   = cnt - 2'd1;
         end else if (tk) begin
            pc_write     = 1'b1;
            pc_src       = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (BR_FLUSH_CYC > 1) begin
               state_nxt = FLUSH;
               cnt_nxt   = win_cnt(BR_FLUSH_CYC);
            end else begin
               state_nxt = RUN;
            end
         end else if (state == STALL || hz) begin
            id_ex_bubble = 1'b1;
            stall_bub    = 1'b1;
            if (state == STALL) begin
               if (cnt == 2'd0) state_nxt = RUN;
               else             cnt_nxt   = cnt - 2'd1;
            end else if (LOAD_STALL_CYC > 1) begin
               state_nxt = STALL;
               cnt_nxt   = win_cnt(LOAD_STALL_CYC);
            end
         end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
         end
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.pc_src       = pc_src;
   assign bus.if_id_write  = if_id_write;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_write  = id_ex_write;
   assign bus.id_ex_bubble = id_ex_bubble;

`ifdef PIPE_HAZARD_PERF_EN
   logic [15:0] stall_cnt, flush_cnt;

   // Freeze forces the qualifying outputs low, so counters hold for free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (stall_bub && stall_cnt != 16'hFFFF)   stall_cnt <= stall_cnt + 16'd1;
         if (if_id_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;
`else
   logic unused_stall_bub;
   assign unused_stall_bub = stall_bub;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (1/1 and 3/3 window lengths) share inputs;
// a window-counting reference model queues expectations, a monitor checks them.
module tb_pipe_hazard_ctrl;
   localparam int RW = 5;
   localparam int LS [2] = '{1, 3};
   localparam int BF [2] = '{1, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          freeze = 0, id_uses_rt = 0, ex_mem_read = 0, ex_branch = 0, ex_zero = 0;
   logic [RW-1:0] id_rs = 0, id_rt = 0, ex_rt = 0;

   pipe_hazard_ctrl_if #(.REG_W(RW)) if_a ();
   pipe_hazard_ctrl_if #(.REG_W(RW)) if_b ();

   assign if_a.freeze = freeze;      assign if_b.freeze = freeze;
   assign if_a.id_rs = id_rs;        assign if_b.id_rs = id_rs;
   assign if_a.id_rt = id_rt;        assign if_b.id_rt = id_rt;
   assign if_a.id_uses_rt = id_uses_rt; assign if_b.id_uses_rt = id_uses_rt;
   assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
   assign if_a.ex_rt = ex_rt;        assign if_b.ex_rt = ex_rt;
   assign if_a.ex_branch = ex_branch; assign if_b.ex_branch = ex_branch;
   assign if_a.ex_zero = ex_zero;    assign if_b.ex_zero = ex_zero;

   pipe_hazard_ctrl #(.REG_W(RW), .LOAD_STALL_CYC(1), .BR_FLUSH_CYC(1))
      u_a (.clk(clk), .rst(rst), .bus(if_a));
   pipe_hazard_ctrl #(.REG_W(RW), .LOAD_STALL_CYC(3), .BR_FLUSH_CYC(3))
      u_b (.clk(clk), .rst(rst), .bus(if_b));

   // {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_RUN   = 6'b101010;
   localparam logic [5:0] O_STALL = 6'b000011;
   localparam logic [5:0] O_BR    = 6'b111111;
   localparam logic [5:0] O_FLUSH = 6'b101111;

   typedef struct {
      logic [5:0]  o;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Model: cycles remaining in the current window and whether it is a flush
   int rem [2];
   bit in_flush [2];
   int sc [2];
   int fc [2];

   int tests = 0;
   int fails = 0;

   task automatic model(input int d, input bit hz, input bit tk, output exp_t e);
      if (rst) begin
         rem[d] = 0; in_flush[d] = 0; sc[d] = 0; fc[d] = 0;
      end
      e.sc = 16'(sc[d]);
      e.fc = 16'(fc[d]);
      if (rst || freeze) begin
         e.o = O_IDLE;
      end else if (rem[d] > 0 && in_flush[d]) begin
         e.o = O_FLUSH; rem[d]--; fc[d]++;
      end else if (tk) begin
         e.o = O_BR; in_flush[d] = 1; rem[d] = BF[d] - 1; fc[d]++;
      end else if (rem[d] > 0 || hz) begin
         e.o = O_STALL; sc[d]++;
         if (rem[d] > 0) rem[d]--;
         else begin in_flush[d] = 0; rem[d] = LS[d] - 1; end
      end else begin
         e.o = O_RUN;
      end
   endtask

   task automatic cyc(input bit r, input bit f, input int rs, input int rt, input bit urt,
                      input bit mr, input int ert, input bit br, input bit z);
      exp_t e;
      bit hz, tk;
      @(posedge clk);
      #1;
      rst = r; freeze = f; id_rs = RW'(rs); id_rt = RW'(rt); id_uses_rt = urt;
      ex_mem_read = mr; ex_rt = RW'(ert); ex_branch = br; ex_zero = z;
      hz = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
      tk = br && z;
      model(0, hz, tk, e); q0.push_back(e);
      model(1, hz, tk, e); q1.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 1, 2, 1, 0, 0, 0, 0);
   endtask

   function automatic logic [5:0] pack_a();
      return {if_a.pc_write, if_a.pc_src, if_a.if_id_write, if_a.if_id_flush,
              if_a.id_ex_write, if_a.id_ex_bubble};
   endfunction

   function automatic logic [5:0] pack_b();
      return {if_b.pc_write, if_b.pc_src, if_b.if_id_write, if_b.if_id_flush,
              if_b.id_ex_write, if_b.id_ex_bubble};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic [5:0] a;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         a = pack_a();
         tests++;
         if (a !== e.o) begin
            fails++;
            $display("FAIL outs_1x1 t=%0t got %b want %b", $time, a, e.o);
         end
`ifdef PIPE_HAZARD_PERF_EN
         tests++;
         if (if_a.stall_cnt !== e.sc || if_a.flush_cnt !== e.fc) begin
            fails++;
            $display("FAIL cnt_1x1 t=%0t got %0d/%0d want %0d/%0d", $time,
                     if_a.stall_cnt, if_a.flush_cnt, e.sc, e.fc);
         end
`endif
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         a = pack_b();
         tests++;
         if (a !== e.o) begin
            fails++;
            $display("FAIL outs_3x3 t=%0t got %b want %b", $time, a, e.o);
         end
`ifdef PIPE_HAZARD_PERF_EN
         tests++;
         if (if_b.stall_cnt !== e.sc || if_b.flush_cnt !== e.fc) begin
            fails++;
            $display("FAIL cnt_3x3 t=%0t got %0d/%0d want %0d/%0d", $time,
                     if_b.stall_cnt, if_b.flush_cnt, e.sc, e.fc);
         end
`endif
      end
   end

   initial begin
      // reset, then idle
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // load-use on rs; $0 destination; rt match without rt use; rt match with use
      cyc(0, 0, 5, 7, 0, 1, 5, 0, 0); idle(4);
      cyc(0, 0, 0, 7, 1, 1, 0, 0, 0); idle(1);
      cyc(0, 0, 6, 5, 0, 1, 5, 0, 0); idle(1);
      cyc(0, 0, 6, 5, 1, 1, 5, 0, 0); idle(4);
      // taken branch, untaken branch
      cyc(0, 0, 1, 2, 0, 0, 0, 1, 1); idle(4);
      cyc(0, 0, 1, 2, 0, 0, 0, 1, 0); idle(1);
      // simultaneous hazard and branch
      cyc(0, 0, 5, 2, 0, 1, 5, 1, 1); idle(4);
      // stall window frozen for 2 cycles
      cyc(0, 0, 5, 2, 0, 1, 5, 0, 0);
      cyc(0, 1, 1, 2, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 2, 0, 0, 0, 0, 0);
      idle(4);
      // branch preempting a stall window
      cyc(0, 0, 5, 2, 0, 1, 5, 0, 0);
      cyc(0, 0, 1, 2, 0, 0, 0, 1, 1); idle(4);
      // reset pulsed mid-flush
      cyc(0, 0, 1, 2, 0, 0, 0, 1, 1);
      cyc(0, 0, 1, 2, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 2, 0, 0, 0, 0, 0);
      idle(4);
      // randomized traffic biased toward register collisions
      for (int i = 0; i < 600; i++)
         cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 99) < 40), int'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 25), 1'($urandom));
      repeat (3) @(posedge clk);
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
